// File: rtl/uart_frame_tx.sv
// Byte-to-serial UART transmitter: start bit, 8 data bits LSB first, STOP_BITS stop bits.
// sendable/done rise during the final stop cycle so a new byte can start with no idle gap.
`ifndef DEFAULT_BAUD
`define DEFAULT_BAUD 4
`endif

module uart_frame_tx #(
    parameter int unsigned BAUD      = `DEFAULT_BAUD,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       order,
    input  logic [7:0] data,
    output logic       sendable,
    output logic       done,
    output logic       txd
);

    localparam int unsigned STOP_LEN = STOP_BITS * BAUD;
    localparam int unsigned CNT_W    = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(BAUD - 1);
    localparam logic [CNT_W-1:0] STOP_LAST   = CNT_W'(STOP_LEN - 1);
    localparam logic [CNT_W-1:0] STOP_PENULT = CNT_W'(STOP_LEN - 2);

    if (BAUD < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_err
        $error("uart_frame_tx: BAUD must be >= 2 and STOP_BITS must be 1 or 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    // Frame sequencer; every output is a register so txd never glitches.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            txd      <= 1'b1;
            sendable <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (order) begin
                        state    <= START;
                        shift    <= data;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        txd      <= 1'b0;
                        sendable <= 1'b0;
                    end
                end
                START: begin
                    if (baud_cnt == BIT_LAST) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        txd      <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (baud_cnt == STOP_LAST) begin
                        baud_cnt <= '0;
                        // A request seen while sendable is high in the last stop cycle chains directly.
                        if (order) begin
                            state    <= START;
                            shift    <= data;
                            bit_idx  <= '0;
                            txd      <= 1'b0;
                            sendable <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                        if (baud_cnt == STOP_PENULT) begin
                            sendable <= 1'b1;
                            done     <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                    txd      <= 1'b1;
                    sendable <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: a line-level model queues the expected txd samples
// per accepted byte, and a monitor compares txd/sendable/done every cycle for two configurations.
module tb_uart_frame_tx;

    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rstn;
    logic [N-1:0] order;
    logic [7:0]   data [N];
    logic [N-1:0] sendable;
    logic [N-1:0] done;
    logic [N-1:0] txd;

    int checks = 0;
    int passes = 0;
    int done_cnt [N];

    always #5 clk = ~clk;

    uart_frame_tx #(.BAUD(4), .STOP_BITS(1)) u_dut_a (
        .clk      (clk),
        .rstn     (rstn),
        .order    (order[0]),
        .data     (data[0]),
        .sendable (sendable[0]),
        .done     (done[0]),
        .txd      (txd[0])
    );

    uart_frame_tx #(.BAUD(5), .STOP_BITS(2)) u_dut_b (
        .clk      (clk),
        .rstn     (rstn),
        .order    (order[1]),
        .data     (data[1]),
        .sendable (sendable[1]),
        .done     (done[1]),
        .txd      (txd[1])
    );

    task automatic check(input string name, input int inst, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s inst%0d: got %b expected %b at %0t", name, inst, act, exp, $time);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) if (done[i] === 1'b1) done_cnt[i]++;
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_sb
        localparam int B     = (gi == 0) ? 4 : 5;
        localparam int SBITS = (gi == 0) ? 1 : 2;

        bit exp_q[$];

        // Reference: an accepted byte becomes (9+SBITS)*B line samples; a request is taken
        // whenever at most the current sample of a frame remains.
        always @(posedge clk or negedge rstn) begin : model
            bit acc;
            if (!rstn) begin
                exp_q.delete();
            end else begin
                acc = order[gi] && (exp_q.size() <= 1);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                if (acc) begin
                    for (int k = 0; k < 9 + SBITS; k++) begin
                        bit v;
                        if (k == 0)      v = 1'b0;
                        else if (k <= 8) v = data[gi][k-1];
                        else             v = 1'b1;
                        repeat (B) exp_q.push_back(v);
                    end
                end
            end
        end

        always @(negedge clk) begin : monitor
            logic et, es, ed;
            et = (exp_q.size() != 0) ? exp_q[0] : 1'b1;
            es = (exp_q.size() <= 1);
            ed = (exp_q.size() == 1);
            check("txd", gi, txd[gi], et);
            check("sendable", gi, sendable[gi], es);
            check("done", gi, done[gi], ed);
        end
    end

    task automatic send(input int i, input logic [7:0] b);
        @(negedge clk);
        order[i] = 1'b1;
        data[i]  = b;
        @(negedge clk);
        order[i] = 1'b0;
        data[i]  = 8'($urandom);
    endtask

    initial begin
        int d0, d1;
        rstn  = 1'b0;
        order = '0;
        for (int i = 0; i < N; i++) begin
            data[i]     = 8'h00;
            done_cnt[i] = 0;
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Idle after reset
        repeat (20) @(negedge clk);
        check_int("idle_done_count", done_cnt[0] + done_cnt[1], 0);

        // Single frame A5
        d0 = done_cnt[0];
        send(0, 8'hA5);
        repeat (45) @(negedge clk);
        check_int("single_done_count", done_cnt[0] - d0, 1);

        // Back-to-back: 00 then FF held on order until the chaining point
        d0 = done_cnt[0];
        @(negedge clk);
        order[0] = 1'b1;
        data[0]  = 8'h00;
        @(negedge clk);
        data[0] = 8'hFF;
        repeat (40) @(negedge clk);
        order[0] = 1'b0;
        repeat (45) @(negedge clk);
        check_int("b2b_done_count", done_cnt[0] - d0, 2);

        // Busy ignore: request and data churn mid-frame
        d0 = done_cnt[0];
        send(0, 8'h5A);
        repeat (6) @(negedge clk);
        order[0] = 1'b1;
        data[0]  = 8'h3C;
        @(negedge clk);
        order[0] = 1'b0;
        repeat (5) @(negedge clk);
        data[0] = 8'hC3;
        repeat (40) @(negedge clk);
        check_int("busy_done_count", done_cnt[0] - d0, 1);

        // Reset during data bit 3, then a fresh byte
        send(0, 8'h96);
        repeat (17) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("async_txd", 0, txd[0], 1'b1);
        check("async_sendable", 0, sendable[0], 1'b1);
        check("async_done", 0, done[0], 1'b0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        d0 = done_cnt[0];
        send(0, 8'h01);
        repeat (45) @(negedge clk);
        check_int("post_reset_done_count", done_cnt[0] - d0, 1);

        // Two stop bits, BAUD 5
        d1 = done_cnt[1];
        send(1, 8'h80);
        repeat (60) @(negedge clk);
        check_int("sb2_done_count", done_cnt[1] - d1, 1);

        // Random traffic on both configurations
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                order[i] = ($urandom_range(0, 5) == 0);
                data[i]  = 8'($urandom);
            end
        end
        order = '0;
        repeat (70) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Byte-to-serial UART transmitter: the transmit-side counterpart of the UART receiver in the core's I/O path.
- Takes one 8-bit byte per handshake from the output cycle buffer and drives it onto txd as an 8N1-style frame: start bit, 8 data bits LSB first, STOP_BITS stop bits.
- Sits between the output cycle_reg and the board TX pin.
- Exposes `sendable` so the buffer only pops a byte when the line is free.

Parameters:
- BAUD, `DEFAULT_BAUD, clock cycles per bit period; legal range >= 2.
- STOP_BITS, 1, number of stop bit periods per frame; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rstn  input  1  asynchronous active-low reset.
- order  input  1  request to send `data`; accepted only in a cycle where sendable=1.
- data  input  8  byte to transmit; sampled only in the accepting cycle.
- sendable  output  1  high when idle and able to accept a byte this cycle.
- done  output  1  one-cycle pulse when a frame's last stop bit completes.
- txd  output  1  serial line, idle high.

Behaviour:
- Reset (rstn=0, asynchronous): txd=1, sendable=1, done=0, state=IDLE, bit counter=0, baud counter=0, shift register=0. This takes effect immediately, including mid-frame; the partial frame is abandoned with no resumption.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - txd=1, sendable=1.
  - If order=1 at the rising edge: latch data into the shift register, go to START, clear the baud counter, sendable=0 from the next cycle.
  - If order=0: remain in IDLE.
- START: txd=0 for exactly BAUD cycles, then go to DATA with bit index 0.
- DATA:
  - txd=shift[0]; each bit is held exactly BAUD cycles.
  - At the end of each bit period: shift right and increment the bit index.
  - After bit index 7 completes, go to STOP.
- STOP:
  - txd=1 for exactly STOP_BITS*BAUD cycles.
  - At the final cycle's edge: go to IDLE, set sendable=1, pulse done=1 for exactly one cycle.
- Frame length: (9+STOP_BITS)*BAUD cycles. The first txd=0 cycle is the cycle after acceptance.
- Back-to-back:
  - order may be asserted in the same cycle done=1 and sendable=1; that byte is accepted.
  - The next start bit then begins immediately after the previous stop period, with no idle gap.
- Ignored inputs:
  - order while sendable=0 is ignored; there is no queuing and the request is not remembered.
  - Changes to data after acceptance do not affect the frame in flight.
- Counter widths:
  - Baud counter: $clog2(STOP_BITS*BAUD) bits, wraps to 0 at each period end.
  - Bit index: 3 bits.
- Glitch-free line: txd is driven from a register, never combinationally from inputs.
- Parameters: BAUD<2 or STOP_BITS outside {1,2} is an elaboration error (assertion in simulation).

Test Plan:
- Reset state: rstn=0 then release, order=0 for 20 cycles -> txd=1, sendable=1, done=0 throughout.
- Single frame (BAUD=4, STOP_BITS=1), order=1 with data=8'hA5 for one cycle:
  - sendable=0 from the next cycle.
  - txd sequence in 4-cycle groups: 0,1,0,1,0,0,1,0,1,1.
  - done pulses once at cycle 40 after acceptance, with sendable=1 in the same cycle.
- Back-to-back (BAUD=4): send 8'h00, then hold order=1 with data=8'hFF when done=1 ->
  - second start bit immediately follows the first stop bit;
  - total 80 cycles, no txd=1 gap longer than 4 cycles between frames.
- Busy ignore: during a frame, pulse order=1 with data=8'h3C and change data mid-frame -> the in-flight frame is unchanged and no second frame is emitted.
- Reset mid-frame: assert rstn=0 during DATA bit 3 -> txd=1 and sendable=1 asynchronously. After release, a new byte 8'h01 transmits correctly from its start bit.
- STOP_BITS=2, BAUD=5, data=8'h80 -> stop period lasts 10 cycles, frame totals 55 cycles, and done is a single pulse.
